if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.

---
 rtl/if_stage_if.sv | 34 +++
 rtl/if_stage.sv | 80 ++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: hazard/redirect controls, instruction-memory port
// and IF/ID outputs. master = surrounding core/bench, slave = if_stage.
interface if_stage_if #(
    parameter int CNT_W = 16
);
    logic             pcwrite;
    logic             hazardflag;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [31:0]      jump_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      pc;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output pcwrite, hazardflag, branch_taken, branch_target,
        output jump, jump_target, imem_rdata,
        input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  pcwrite, hazardflag, branch_taken, branch_target,
        input  jump, jump_target, imem_rdata,
        output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register. Ports: clk, rst (async, active-high),
// bus (if_stage_if.slave): hazard/redirect inputs, imem port, IF/ID + counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.slave   bus
);
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc4;

    always_comb begin
        redirect = bus.branch_taken | bus.jump;
        // Branch has priority over a simultaneous jump.
        target   = bus.branch_taken ? bus.branch_target : bus.jump_target;
        target   = {target[31:2], 2'b00};
        pc4      = pc_q + 32'd4;

        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;

        if (redirect) begin
            // Flush wins over any stall request.
            pc_d    = target;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
            if (flush_q != {CNT_W{1'b1}}) flush_d = flush_q + 1'b1;
        end else if (bus.hazardflag) begin
            if (bus.pcwrite) pc_d = pc4;
            if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
        end else begin
            instr_d = bus.imem_rdata;
            pc4_d   = pc4;
            valid_d = 1'b1;
            if (bus.pcwrite) pc_d = pc4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.ifid_instr = instr_q;
    assign bus.ifid_pc4   = pc4_q;
    assign bus.ifid_valid = valid_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
endmodule
